// File: rtl/control_unit.sv
// control_unit: hardwired Moore control FSM for the single-bus datapath.
// Fetch in T0-T2, per-opcode-class execute from T3, halt on halt or Stop.
module control_unit #(
    parameter int unsigned    OPW     = 5,
    parameter logic [OPW-1:0] ALU_ADD = 5'b00011
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Stop,
    input  logic [31:0]    IR,
    input  logic           CON_out,
    output logic           PCout,
    output logic           Zlowout,
    output logic           ZHighout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           InPortout,
    output logic           Cout,
    output logic           BAout,
    output logic           PCin,
    output logic           IRin,
    output logic           MARin,
    output logic           MDRin,
    output logic           Yin,
    output logic           Zin,
    output logic           HIin,
    output logic           LOin,
    output logic           CONin,
    output logic           OutPortin,
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
    output logic           GRA,
    output logic           GRB,
    output logic           GRC,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] operation,
    output logic           Run
);

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(7);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(8);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(9);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(10);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(11);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(12);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(13);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(14);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(16);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(17);
    localparam logic [OPW-1:0] OP_BR   = OPW'(18);
    localparam logic [OPW-1:0] OP_JR   = OPW'(19);
    localparam logic [OPW-1:0] OP_IN   = OPW'(20);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(21);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(22);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(23);
    localparam logic [OPW-1:0] OP_HALT = OPW'(25);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM,
        C_MULDIV, C_UNARY, C_BR, C_JR, C_IN,
        C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_e;

    state_e         state;
    state_e         nxt;
    cls_e           cls;
    logic [OPW-1:0] opc;
    logic [OPW-1:0] imm_op;
    logic           stop_req;
    logic           done;
    logic           unused_ir;

    assign opc       = IR[31 -: OPW];
    assign unused_ir = ^IR[31-OPW:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_RST;
            stop_req <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_T0)
                stop_req <= Stop;
        end
    end

    // Immediate forms reuse the ALU code of their reg-reg counterpart.
    always_comb begin
        cls    = C_NOP;
        imm_op = ALU_ADD;
        case (opc)
            OP_LD:   cls = C_LD;
            OP_LDI:  cls = C_LDI;
            OP_ST:   cls = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                     cls = C_ALU;
            OP_ADDI: begin cls = C_IMM; imm_op = OP_ADD; end
            OP_ANDI: begin cls = C_IMM; imm_op = OP_AND; end
            OP_ORI:  begin cls = C_IMM; imm_op = OP_OR;  end
            OP_MUL, OP_DIV: cls = C_MULDIV;
            OP_NEG, OP_NOT: cls = C_UNARY;
            OP_BR:   cls = C_BR;
            OP_JR:   cls = C_JR;
            OP_IN:   cls = C_IN;
            OP_OUT:  cls = C_OUT;
            OP_MFHI: cls = C_MFHI;
            OP_MFLO: cls = C_MFLO;
            OP_HALT: cls = C_HALT;
            default: cls = C_NOP;
        endcase
    end

    always_comb begin
        {PCout, Zlowout, ZHighout, MDRout, HIout, LOout,
         InPortout, Cout, BAout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
         CONin, OutPortin} = '0;
        {IncPC, Read, Write} = '0;
        {GRA, GRB, GRC, Rin, Rout} = '0;
        operation = '0;
        Run       = 1'b1;
        done      = 1'b0;
        nxt       = state;
        case (state)
            S_RST: nxt = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1;
                IncPC = 1'b1; PCin  = 1'b1;
                nxt   = S_T1;
            end
            S_T1: begin
                Read = 1'b1; MDRin = 1'b1;
                nxt  = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                nxt    = S_T3;
            end
            S_T3: begin
                nxt = S_T4;
                case (cls)
                    C_LD, C_LDI, C_ST: begin
                        GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    C_ALU, C_IMM: begin
                        GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    C_UNARY: begin
                        GRB = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        operation = opc;
                    end
                    C_MULDIV: begin
                        GRA = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    C_BR: begin
                        GRB = 1'b1; Rout = 1'b1; CONin = 1'b1;
                    end
                    C_JR: begin
                        GRA = 1'b1; Rout = 1'b1; PCin = 1'b1;
                        done = 1'b1;
                    end
                    C_IN: begin
                        InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                        done = 1'b1;
                    end
                    C_OUT: begin
                        GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
                        done = 1'b1;
                    end
                    C_MFHI: begin
                        HIout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                        done = 1'b1;
                    end
                    C_MFLO: begin
                        LOout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                        done = 1'b1;
                    end
                    C_HALT:  nxt  = S_HALT;
                    default: done = 1'b1;
                endcase
            end
            S_T4: begin
                nxt = S_T5;
                case (cls)
                    C_LD, C_LDI, C_ST: begin
                        Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD;
                    end
                    C_ALU: begin
                        GRC = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        operation = opc;
                    end
                    C_IMM: begin
                        Cout = 1'b1; Zin = 1'b1; operation = imm_op;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                        done = 1'b1;
                    end
                    C_MULDIV: begin
                        GRB = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        operation = opc;
                    end
                    C_BR: begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            S_T5: begin
                nxt = S_T6;
                case (cls)
                    C_LDI, C_ALU, C_IMM: begin
                        Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                        done = 1'b1;
                    end
                    C_LD, C_ST: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                    C_BR: begin
                        Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD;
                    end
                    default: done = 1'b1;
                endcase
            end
            S_T6: begin
                nxt = S_T7;
                case (cls)
                    C_LD: begin
                        Read = 1'b1; MDRin = 1'b1;
                    end
                    C_ST: begin
                        GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end
                    C_MULDIV: begin
                        ZHighout = 1'b1; HIin = 1'b1;
                        done = 1'b1;
                    end
                    C_BR: begin
                        Zlowout = CON_out; PCin = CON_out;
                        done = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            S_T7: begin
                done = 1'b1;
                case (cls)
                    C_LD: begin
                        MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end
                    C_ST:    Write = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: Run = 1'b0;
            default: nxt = S_RST;
        endcase
        // A Stop seen in T0 diverts the instruction's return to HALT.
        if (done)
            nxt = stop_req ? S_HALT : S_T0;
    end

endmodule
